// File: rtl/fruit_pkg.sv
// Shared types, screen geometry and LFSR step for the fruit game blocks.
package fruit_pkg;

  typedef logic [9:0]        coord_t;
  typedef logic signed [9:0] vel_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    LAUNCH = 3'd2,
    FLIGHT = 3'd3,
    CUT    = 3'd4,
    MISS   = 3'd5,
    OVER   = 3'd6
  } state_e;

  localparam coord_t SCREEN_W = 10'd640;
  localparam coord_t SCREEN_H = 10'd480;
  localparam coord_t X_MIN    = 10'd40;
  localparam coord_t X_HALF   = 10'd320;
  // Rising above this line arms the bottom-edge exit test.
  localparam coord_t Y_ASCEND = SCREEN_H - 10'd16;
  localparam coord_t Y_EXIT   = SCREEN_H - 10'd1;

  // Galois step for x^16+x^14+x^13+x^11+1; a nonzero state never maps to zero.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? 16'hB400 : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, shared by the random-placement blocks.
module lfsr16
  import fruit_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Next value of the shift register.
  always_comb begin
    state_d = lfsr16_next(state_q);
  end

  // State register, steps every clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/fruit_launcher.sv
// Game-side controller: launches fruit with LFSR trajectories, detects blade
// hits and screen exits, and keeps score, lives and game-over.
module fruit_launcher
  import fruit_pkg::*;
#(
  parameter int unsigned SPAWN_DELAY = 60,
  parameter int unsigned HIT_RADIUS  = 8,
  parameter int unsigned MAX_LIVES   = 3,
  parameter int unsigned FLIGHT_MAX  = 255,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       game_en,
  input  logic [9:0] blade_x,
  input  logic [9:0] blade_y,
  input  logic       blade_valid,
  input  logic [9:0] fruit_x,
  input  logic [9:0] fruit_y,
  input  logic [9:0] fruit_s,
  output logic       new_fruit,
  output logic [9:0] launch_x,
  output logic [9:0] launch_vx,
  output logic [9:0] launch_vy,
  output logic       move_fruit,
  output logic       fruit_active,
  output logic [7:0] cut_count,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam logic [15:0] WAIT_RELOAD = 16'(SPAWN_DELAY - 1);
  localparam logic [10:0] HIT_R       = 11'(HIT_RADIUS);
  localparam logic [1:0]  LIVES_INIT  = 2'(MAX_LIVES);
  localparam logic [15:0] FLIGHT_LIM  = 16'(FLIGHT_MAX);

  state_e      state_q,     state_d;
  logic [15:0] wait_q,      wait_d;
  logic [15:0] flight_q,    flight_d;
  logic        asc_q,       asc_d;
  logic        new_fruit_q, new_fruit_d;
  coord_t      launch_x_q,  launch_x_d;
  vel_t        launch_vx_q, launch_vx_d;
  vel_t        launch_vy_q, launch_vy_d;
  logic        move_q,      move_d;
  logic [7:0]  cut_q,       cut_d;
  logic [1:0]  lives_q,     lives_d;
  logic        over_q,      over_d;

  logic [15:0] lfsr;
  logic        lfsr_unused;
  logic [10:0] dx, dy, hit_bound;
  logic        hit, miss;
  coord_t      cand_x;
  logic [9:0]  speed;
  vel_t        cand_vx, cand_vy;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i   (frame_clk),
    .rst_i   (Reset),
    .state_o (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:14];

  // Distances are taken at 11 bits so the bound HIT_RADIUS+size cannot wrap.
  assign dx = (blade_x >= fruit_x) ? ({1'b0, blade_x} - {1'b0, fruit_x})
                                   : ({1'b0, fruit_x} - {1'b0, blade_x});
  assign dy = (blade_y >= fruit_y) ? ({1'b0, blade_y} - {1'b0, fruit_y})
                                   : ({1'b0, fruit_y} - {1'b0, blade_y});
  assign hit_bound = HIT_R + {1'b0, fruit_s};
  assign hit  = blade_valid && (dx <= hit_bound) && (dy <= hit_bound);
  assign miss = (asc_q && (fruit_y >= Y_EXIT)) || (fruit_x >= SCREEN_W) ||
                (flight_q == FLIGHT_LIM);

  assign cand_x  = X_MIN + {1'b0, lfsr[8:0]};
  assign speed   = 10'd1 + {8'd0, lfsr[10:9]};
  assign cand_vx = (cand_x < X_HALF) ? vel_t'(speed) : vel_t'(10'd0 - speed);
  assign cand_vy = vel_t'(10'd0 - (10'd8 + {7'd0, lfsr[13:11]}));

  // Next-state, counters, score/lives and next registered outputs.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    flight_d    = flight_q;
    asc_d       = asc_q;
    launch_x_d  = launch_x_q;
    launch_vx_d = launch_vx_q;
    launch_vy_d = launch_vy_q;
    cut_d       = cut_q;
    lives_d     = lives_q;
    if (!game_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT;
          wait_d  = WAIT_RELOAD;
          lives_d = LIVES_INIT;
          cut_d   = 8'd0;
        end
        WAIT: begin
          if (wait_q == 16'd0) begin
            state_d     = LAUNCH;
            launch_x_d  = cand_x;
            launch_vx_d = cand_vx;
            launch_vy_d = cand_vy;
          end else begin
            wait_d = wait_q - 16'd1;
          end
        end
        LAUNCH: begin
          state_d  = FLIGHT;
          flight_d = 16'd0;
          asc_d    = 1'b0;
        end
        FLIGHT: begin
          flight_d = flight_q + 16'd1;
          asc_d    = asc_q | (fruit_y < Y_ASCEND);
          // A hit outranks a simultaneous exit or timeout.
          if (hit) begin
            state_d = CUT;
            cut_d   = (cut_q != 8'hFF) ? (cut_q + 8'd1) : cut_q;
          end else if (miss) begin
            state_d = MISS;
            lives_d = (lives_q != 2'd0) ? (lives_q - 2'd1) : lives_q;
          end else begin
            state_d = FLIGHT;
          end
        end
        CUT: begin
          state_d = WAIT;
          wait_d  = WAIT_RELOAD;
        end
        MISS: begin
          if (lives_q == 2'd0) begin
            state_d = OVER;
          end else begin
            state_d = WAIT;
            wait_d  = WAIT_RELOAD;
          end
        end
        OVER: begin
          state_d = OVER;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    new_fruit_d = (state_d == LAUNCH);
    move_d      = (state_d == FLIGHT);
    over_d      = (state_d == OVER);
  end

  // State and output registers.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      wait_q      <= 16'd0;
      flight_q    <= 16'd0;
      asc_q       <= 1'b0;
      new_fruit_q <= 1'b0;
      launch_x_q  <= X_MIN;
      launch_vx_q <= 10'sd0;
      launch_vy_q <= 10'sd0;
      move_q      <= 1'b0;
      cut_q       <= 8'd0;
      lives_q     <= LIVES_INIT;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      flight_q    <= flight_d;
      asc_q       <= asc_d;
      new_fruit_q <= new_fruit_d;
      launch_x_q  <= launch_x_d;
      launch_vx_q <= launch_vx_d;
      launch_vy_q <= launch_vy_d;
      move_q      <= move_d;
      cut_q       <= cut_d;
      lives_q     <= lives_d;
      over_q      <= over_d;
    end
  end

  assign new_fruit    = new_fruit_q;
  assign launch_x     = launch_x_q;
  assign launch_vx    = launch_vx_q;
  assign launch_vy    = launch_vy_q;
  assign move_fruit   = move_q;
  assign fruit_active = move_q;
  assign cut_count    = cut_q;
  assign lives        = lives_q;
  assign game_over    = over_q;

endmodule

// File: tb/tb_fruit_launcher.sv
// Self-checking bench for fruit_launcher: a frame-level game model is compared
// against every output each frame under directed and random stimulus.
`timescale 1ns/1ps
module tb_fruit_launcher;
  localparam int SD = 4;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       game_en;
  logic [9:0] blade_x, blade_y, fruit_x, fruit_y, fruit_s;
  logic       blade_valid;
  logic       new_fruit, move_fruit, fruit_active, game_over;
  logic [9:0] launch_x, launch_vx, launch_vy;
  logic [7:0] cut_count;
  logic [1:0] lives;

  fruit_launcher #(.SPAWN_DELAY(SD)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .game_en(game_en),
    .blade_x(blade_x), .blade_y(blade_y), .blade_valid(blade_valid),
    .fruit_x(fruit_x), .fruit_y(fruit_y), .fruit_s(fruit_s),
    .new_fruit(new_fruit), .launch_x(launch_x), .launch_vx(launch_vx),
    .launch_vy(launch_vy), .move_fruit(move_fruit), .fruit_active(fruit_active),
    .cut_count(cut_count), .lives(lives), .game_over(game_over)
  );

  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_err    = 0;

  // Game model: what the player would see, frame by frame.
  logic [15:0] m_lfsr;
  bit m_idle, m_pulse, m_air, m_risen, m_dead;
  int m_wait, m_air_frames, m_resolve, m_cuts, m_lives, m_hits;
  int m_lx, m_vx, m_vy;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr = 16'hACE1; m_idle = 1'b1; m_pulse = 1'b0; m_air = 1'b0; m_risen = 1'b0;
    m_dead = 1'b0; m_wait = -1; m_air_frames = 0; m_resolve = 0;
    m_cuts = 0; m_lives = 3; m_lx = 40; m_vx = 0; m_vy = 0;
  endtask

  task automatic model_step();
    int dx, dy, bound, speed;
    bit hit, gone;
    if (!game_en) begin
      m_idle = 1'b1; m_wait = -1; m_pulse = 1'b0; m_air = 1'b0; m_resolve = 0; m_dead = 1'b0;
    end else if (m_idle) begin
      m_idle = 1'b0; m_wait = SD - 1; m_lives = 3; m_cuts = 0;
    end else if (m_dead) begin
      m_dead = 1'b1;
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (m_wait == 0) begin
      m_wait = -1; m_pulse = 1'b1;
      m_lx  = 40 + int'(m_lfsr & 16'h01FF);
      speed = 1 + int'((m_lfsr >> 9) & 16'h0003);
      m_vx  = (m_lx < 320) ? speed : -speed;
      m_vy  = -(8 + int'((m_lfsr >> 11) & 16'h0007));
    end else if (m_pulse) begin
      m_pulse = 1'b0; m_air = 1'b1; m_air_frames = 0; m_risen = 1'b0;
    end else if (m_air) begin
      dx = iabs(int'(blade_x) - int'(fruit_x));
      dy = iabs(int'(blade_y) - int'(fruit_y));
      bound = 8 + int'(fruit_s);
      hit  = blade_valid && (dx <= bound) && (dy <= bound);
      gone = (m_risen && fruit_y >= 10'd479) || (fruit_x >= 10'd640) || (m_air_frames == 255);
      if (hit) begin
        m_air = 1'b0; m_resolve = 1; m_hits++;
        if (m_cuts < 255) m_cuts++;
      end else if (gone) begin
        m_air = 1'b0; m_resolve = 2; m_lives--;
      end else begin
        m_air_frames++;
        if (fruit_y < 10'd464) m_risen = 1'b1;
      end
    end else if (m_resolve == 1) begin
      m_resolve = 0; m_wait = SD - 1;
    end else if (m_resolve == 2) begin
      m_resolve = 0;
      if (m_lives == 0) m_dead = 1'b1;
      else m_wait = SD - 1;
    end
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  task automatic check_all();
    chk("new_fruit",    16'(new_fruit),    16'(m_pulse));
    chk("launch_x",     16'(launch_x),     16'(m_lx & 1023));
    chk("launch_vx",    16'(launch_vx),    16'(m_vx & 1023));
    chk("launch_vy",    16'(launch_vy),    16'(m_vy & 1023));
    chk("move_fruit",   16'(move_fruit),   16'(m_air));
    chk("fruit_active", 16'(fruit_active), 16'(m_air));
    chk("cut_count",    16'(cut_count),    16'(m_cuts));
    chk("lives",        16'(lives),        16'(m_lives));
    chk("game_over",    16'(game_over),    16'(m_dead));
  endtask

  // One frame: model and DUT both take the edge, outputs compared just after.
  task automatic frame();
    @(posedge frame_clk);
    model_step();
    #1;
    check_all();
    @(negedge frame_clk);
  endtask

  task automatic set_fruit(input int x, input int y, input int s);
    fruit_x = 10'(x); fruit_y = 10'(y); fruit_s = 10'(s);
  endtask

  task automatic set_blade(input int x, input int y, input bit v);
    blade_x = 10'(x); blade_y = 10'(y); blade_valid = v;
  endtask

  task automatic run_until_air(input string tag);
    int n = 0;
    while (!move_fruit && n < 100) begin frame(); n++; end
    chk(tag, 16'(move_fruit), 16'd1);
  endtask

  task automatic restart();
    game_en = 1'b0; frame();
    game_en = 1'b1;
  endtask

  initial begin
    int cnt, bx, by;
    Reset = 1'b1; game_en = 1'b0;
    set_fruit(300, 479, 4); set_blade(0, 0, 1'b0);
    model_reset();
    @(negedge frame_clk);
    check_all();
    @(negedge frame_clk);
    Reset = 1'b0;
    frame(); frame();

    // First launch and its latency.
    game_en = 1'b1;
    cnt = 0;
    while (!new_fruit && cnt < 20) begin frame(); cnt++; end
    chk("launch_latency", 16'(cnt), 16'd5);
    chk("launch_x_range", 16'(launch_x >= 10'd40 && launch_x <= 10'd551), 16'd1);
    chk("launch_vy_range", 16'($signed(launch_vy) <= -10'sd8 && $signed(launch_vy) >= -10'sd15), 16'd1);
    chk("launch_vx_side", 16'(launch_vx[9]), 16'(launch_x >= 10'd320));
    frame();
    chk("one_frame_pulse", 16'(new_fruit), 16'd0);

    // Hit window.
    set_fruit(300, 200, 4); set_blade(313, 205, 1'b1);
    frame();
    chk("no_hit_dx13", 16'(move_fruit), 16'd1);
    set_blade(310, 205, 1'b0);
    frame();
    chk("no_hit_invalid", 16'(move_fruit), 16'd1);
    set_blade(310, 205, 1'b1);
    frame();
    chk("hit_cut", 16'(cut_count), 16'd1);
    chk("hit_move_off", 16'(move_fruit), 16'd0);
    set_blade(0, 0, 1'b0); set_fruit(300, 479, 4);

    // Bottom exit after rising.
    run_until_air("air_miss");
    frame();
    fruit_y = 10'd400; frame();
    fruit_y = 10'd479; frame();
    chk("miss_lives", 16'(lives), 16'd2);

    // Hit beats a same-frame exit.
    run_until_air("air_prio");
    fruit_y = 10'd400; frame();
    fruit_y = 10'd479; set_blade(300, 479, 1'b1); frame();
    chk("prio_cut", 16'(cut_count), 16'd2);
    chk("prio_lives", 16'(lives), 16'd2);
    set_blade(0, 0, 1'b0);

    // Flight timeout.
    run_until_air("air_timeout");
    cnt = 0;
    while (move_fruit && cnt < 300) begin frame(); cnt++; end
    chk("timeout_frames", 16'(cnt), 16'd256);
    chk("timeout_lives", 16'(lives), 16'd1);

    // Abort mid-flight and re-enable.
    run_until_air("air_abort");
    frame();
    game_en = 1'b0; frame();
    chk("abort_move", 16'(move_fruit), 16'd0);
    chk("abort_cut_held", 16'(cut_count), 16'd2);
    game_en = 1'b1; frame();
    chk("reenable_cut", 16'(cut_count), 16'd0);
    chk("reenable_lives", 16'(lives), 16'd3);

    // Random play.
    for (int i = 0; i < 1500; i++) begin
      set_fruit(int'($urandom_range(0, 660)), int'($urandom_range(0, 500)),
                int'($urandom_range(0, 20)));
      bx = int'(fruit_x) + int'($urandom_range(0, 30)) - 15;
      by = int'(fruit_y) + int'($urandom_range(0, 30)) - 15;
      set_blade((bx < 0) ? 0 : bx, (by < 0) ? 0 : by, ($urandom_range(0, 3) == 0));
      game_en = !(m_dead || ($urandom_range(0, 99) == 0));
      frame();
    end

    // Three misses end the game; no launches afterwards.
    set_blade(0, 0, 1'b0); set_fruit(650, 479, 4);
    restart();
    cnt = 0;
    while (!game_over && cnt < 200) begin frame(); cnt++; end
    chk("over_flag", 16'(game_over), 16'd1);
    chk("over_lives", 16'(lives), 16'd0);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin frame(); if (new_fruit) cnt++; end
    chk("over_no_launch", 16'(cnt), 16'd0);

    // Cut counter saturation.
    set_fruit(300, 479, 4); set_blade(300, 479, 1'b1);
    restart();
    m_hits = 0;
    cnt = 0;
    while (m_hits < 260 && cnt < 4000) begin frame(); cnt++; end
    chk("sat_hits_bound", 16'(cnt < 4000), 16'd1);
    chk("sat_count", 16'(cut_count), 16'd255);
    set_blade(0, 0, 1'b0);

    // Asynchronous reset while waiting to launch.
    restart();
    frame(); frame();
    #2 Reset = 1'b1;
    #1 model_reset();
    check_all();
    chk("rst_async_cut", 16'(cut_count), 16'd0);
    @(posedge frame_clk); #1 check_all();
    @(negedge frame_clk);
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) frame();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
